// File: rtl/stp_defs.sv
// Shared stopwatch definitions: run-control state encoding and counter limits.
package stp_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam int unsigned SEC_MAX   = 59;
  localparam int unsigned CENTI_MAX = 99;
  localparam int unsigned VAL_W     = 8;

endpackage

// File: rtl/stp_prescaler.sv
// Clock-enable prescaler: counts 0..DIV-1 while en, wraps, and flags the last count.
module stp_prescaler #(
  parameter int unsigned DIV   = 10,
  parameter int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(DIV - 1));

  // clr dominates so a paused count can still be discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stp_count_sec.sv
// Stopwatch seconds stage plus start/pause/clear run control for downstream counters.
// Optional STP_SEC_CENTI_EN: 10 ms prescaler tick and a 0-99 centiseconds counter.
module stp_count_sec
  import stp_defs::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  localparam int unsigned CNT_W = $clog2(TICKS_PER_SEC)
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       start_pause,
  input  logic       clear,
  output logic       stop,
  output logic       rst_counters,
  output logic       running,
  output logic       count_up_min,
  output logic [7:0] secs,
  output logic [7:0] centis
);

`ifdef STP_SEC_CENTI_EN
  localparam int unsigned DIV = TICKS_PER_SEC / 100;
`else
  localparam int unsigned DIV = TICKS_PER_SEC;
`endif

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       tick;
  logic       sec_step;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // clear wins over start_pause; unused encoding falls back to IDLE
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else if (start_pause) begin
      case (state)
        ST_IDLE:  state_nxt = ST_RUN;
        ST_RUN:   state_nxt = ST_PAUSE;
        ST_PAUSE: state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign stop    = (state == ST_IDLE);
  assign running = (state == ST_RUN);

  stp_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_presc (
    .clk   (CLK),
    .rst_n (rst_n),
    .en    (running),
    .clr   (clear || stop),
    .tick  (tick)
  );

`ifdef STP_SEC_CENTI_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      centis <= '0;
    end else if (clear) begin
      centis <= '0;
    end else if (tick) begin
      centis <= (centis == 8'(CENTI_MAX)) ? '0 : centis + 8'd1;
    end
  end

  assign sec_step = tick && (centis == 8'(CENTI_MAX));
`else
  assign centis   = '0;
  assign sec_step = tick;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      secs <= '0;
    end else if (clear) begin
      secs <= '0;
    end else if (sec_step) begin
      secs <= (secs == 8'(SEC_MAX)) ? '0 : secs + 8'd1;
    end
  end

  // Carry is valid in the cycle before the wrap edge so minutes step with it
  assign count_up_min = sec_step && (secs == 8'(SEC_MAX));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) rst_counters <= 1'b0;
    else        rst_counters <= clear;
  end

endmodule

// File: tb/tb_stp_count_sec.sv
// Scoreboard bench for stp_count_sec: model tracks elapsed running cycles and derives outputs.
module tb_stp_count_sec;

  localparam int unsigned TPS = 10;
  localparam int unsigned MIN_CYC = 60 * TPS;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_pause = 1'b0;
  logic       clear = 1'b0;
  logic       stop;
  logic       rst_counters;
  logic       running;
  logic       count_up_min;
  logic [7:0] secs;
  logic [7:0] centis;

  stp_count_sec #(.TICKS_PER_SEC(TPS)) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .start_pause  (start_pause),
    .clear        (clear),
    .stop         (stop),
    .rst_counters (rst_counters),
    .running      (running),
    .count_up_min (count_up_min),
    .secs         (secs),
    .centis       (centis)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       stop;
    logic       running;
    logic       rstc;
    logic       cum;
    logic [7:0] secs;
    logic [7:0] centis;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int m_pulses = 0;
  int dut_pulses = 0;

  // Reference model: stopwatch is active/paused; time is total running cycles since zero
  bit m_active = 0;
  bit m_paused = 0;
  int m_el = 0;
  bit m_rstc = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic do_cycle(input logic cl, input logic sp, input logic rn);
    exp_t e;
    @(negedge CLK);
    clear = cl;
    start_pause = sp;
    rst_n = rn;
    if (!rn) begin
      m_active = 0; m_paused = 0; m_el = 0; m_rstc = 0;
    end else begin
      m_rstc = cl;
      if (cl) begin
        m_active = 0; m_paused = 0; m_el = 0;
      end else begin
        if (m_active && !m_paused) m_el++;
        if (sp) begin
          if (!m_active) m_active = 1;
          else m_paused = !m_paused;
        end
      end
    end
    e.stop    = !m_active;
    e.running = m_active && !m_paused;
    e.rstc    = m_rstc;
    e.cum     = e.running && ((m_el % MIN_CYC) == MIN_CYC - 1);
    e.secs    = 8'((m_el / TPS) % 60);
    e.centis  = 8'd0;
    if (e.cum) m_pulses++;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b1);
  endtask

  function automatic bit is_running();
    return m_active && !m_paused;
  endfunction

  // Monitor: every cycle the DUT presents a fresh output set
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (count_up_min) dut_pulses++;
        check("stop",         int'(stop),         int'(e.stop));
        check("running",      int'(running),      int'(e.running));
        check("rst_counters", int'(rst_counters), int'(e.rstc));
        check("count_up_min", int'(count_up_min), int'(e.cum));
        check("secs",         int'(secs),         int'(e.secs));
        check("centis",       int'(centis),       int'(e.centis));
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1'b0);

    // idle after reset
    idle(50);

    // start, then run past a full minute so secs wraps 59 -> 0
    do_cycle(1'b0, 1'b1, 1'b1);
    idle(650);

    // pause with prescaler at 4, hold, resume
    guard = 0;
    while ((m_el % TPS) != 4 && guard < 100) begin idle(1); guard++; end
    check("pause_align", m_el % TPS, 4);
    do_cycle(1'b0, 1'b1, 1'b1);
    idle(37);
    do_cycle(1'b0, 1'b1, 1'b1);
    idle(20);

    // clear + start_pause together at secs 23
    guard = 0;
    while (((m_el / TPS) % 60) != 23 && guard < 2000) begin idle(1); guard++; end
    check("clear_align", (m_el / TPS) % 60, 23);
    do_cycle(1'b1, 1'b1, 1'b1);
    idle(10);

    // reset mid-run at secs 59, prescaler 8
    do_cycle(1'b0, 1'b1, 1'b1);
    guard = 0;
    while ((m_el % MIN_CYC) != MIN_CYC - 2 && guard < 2000) begin idle(1); guard++; end
    check("reset_align", m_el % MIN_CYC, MIN_CYC - 2);
    do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0);
    idle(10);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic cl, sp, rn;
      cl = ($urandom_range(0, 199) == 0);
      sp = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 599) != 0);
      do_cycle(cl, sp, rn);
    end
    if (!is_running()) do_cycle(1'b0, 1'b1, 1'b1);
    idle(MIN_CYC + 5);

    repeat (3) @(posedge CLK);
    #2;
    check("queue_drained", q.size(), 0);
    check("carry_pulses", dut_pulses, m_pulses);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stp_count_sec.md
Name: stp_count_sec

Overview:
Seconds stage and run-control for the stopwatch timer. It divides CLK down to a 1 s tick (or a 10 ms tick with the optional feature), counts seconds 0-59 and emits count_up_min to the minutes stage. It also owns the start/pause/clear state machine and drives the stop and rst_counters controls shared by all downstream stopwatch counters.

Parameters:
TICKS_PER_SEC, 50_000_000, CLK cycles per second; must be >= 2, and a multiple of 100 when STP_SEC_CENTI_EN is defined.
CNT_W, $clog2(TICKS_PER_SEC), prescaler width (derived; not overridden).

Ports:
CLK  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
start_pause  input  1  single-cycle pulse (pre-debounced); toggles run/pause
clear  input  1  single-cycle pulse; returns stopwatch to zero/idle
stop  output  1  level, high while IDLE; holds downstream counters at zero
rst_counters  output  1  registered one-cycle pulse on clear, for downstream counters
running  output  1  high while RUNNING
count_up_min  output  1  one-cycle carry to minutes stage
secs  output  8  seconds value 0-59, binary
centis  output  8  centiseconds 0-99 (feature only; otherwise constant 0)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; prescaler = 0; secs = 0; centis = 0.
  - rst_counters = 0; count_up_min = 0; running = 0; stop = 1.
- FSM states: IDLE, RUNNING, PAUSED. Transitions on start_pause:
  - IDLE -> RUNNING
  - RUNNING -> PAUSED
  - PAUSED -> RUNNING
- clear pulse in any state:
  - Next state is IDLE; prescaler, secs and centis are zeroed.
  - rst_counters = 1 for exactly the following cycle.
  - clear wins over a simultaneous start_pause.
- Output decode: stop = (state == IDLE); running = (state == RUNNING). Both are decoded from the state register.
- Prescaler behaviour by state:
  - RUNNING: counts 0..TICKS_PER_SEC-1 and wraps.
  - PAUSED: holds its value, so the fractional second is preserved and resumed.
  - IDLE: held at 0.
- tick = RUNNING && prescaler == TICKS_PER_SEC-1 (internal).
- Seconds counter:
  - On tick, secs increments. At 59 it wraps to 0 on the same edge.
  - count_up_min = tick && secs == 59. It is combinational from registers and lasts one cycle, aligned so the minutes stage increments on the same edge that secs wraps.
- Latency:
  - A start_pause sampled at edge k makes RUNNING visible after edge k.
  - secs reads 1 after edge k+TICKS_PER_SEC.
- Pause near the boundary: a start_pause coinciding with tick still completes that increment; pausing takes effect from the next cycle.
- start_pause asserted in consecutive cycles toggles each cycle; no internal edge filtering.
- Reset asserted mid-operation: immediate return to the reset values; no carry is emitted.

Optional Feature:
STP_SEC_CENTI_EN
- Defined:
  - The prescaler divides by TICKS_PER_SEC/100 and produces a 10 ms tick.
  - centis counts 0-99. secs increments only when centis wraps 99 -> 0.
  - count_up_min = centi tick && centis == 99 && secs == 59.
  - clear, IDLE and reset zero centis; PAUSED holds it.
- Undefined: centis is constant 0, and the seconds path is exactly as described above.

Decomposition:
- Shared stopwatch header/package stp_defs:
  - FSM state encoding: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2.
  - Constants SEC_MAX = 59 and CENTI_MAX = 99.
- One natural sub-module, stp_prescaler:
  - Parameter DIV; inputs en and clr; output tick.
  - Reused later by the countdown timer.
- The FSM and the seconds/centis counters stay in stp_count_sec.

Test Plan:
All scenarios run with TICKS_PER_SEC = 10.
1. Reset release, no stimulus for 50 cycles -> stop = 1, running = 0, secs = 0, count_up_min never high.
2. start_pause at cycle 0 -> running = 1 next cycle; secs = 1 exactly 10 cycles after the start edge; secs = 5 after 50 cycles.
3. Run 600 cycles -> secs steps 58 -> 59 -> 0; count_up_min high exactly one cycle, in the cycle before the wrap edge; no other pulses.
4. Pause with prescaler = 4, hold 37 cycles, resume -> secs unchanged during the pause; the next increment comes 6 cycles after resume.
5. clear and start_pause in the same cycle while RUNNING at secs = 23 -> state IDLE, secs = 0, stop = 1, rst_counters high for exactly one cycle.
6. rst_n low mid-run at secs = 59, prescaler = 8 -> immediate zeroing with no count_up_min. With STP_SEC_CENTI_EN, also check centis 99 -> 0 carrying into secs.
